router_reg_gen: RTL and testbench

- Parametrised packet register stage for the router input path.
- Accepts a header/payload/parity byte stream and buffers beats in a small hold queue ahead of the destination FIFO.
- Computes running XOR parity and checks the payload length against the header length field.
- Reports parity and length errors with sticky flags and a saturating error counter.
- Contains its own packet FSM, so no external state decodes are needed.

---
 rtl/router_reg_gen.sv | 198 +++++++++++++++++++
 tb/tb_router_reg_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_reg_gen.sv
// router_reg_gen: packet register stage on the router input path.
//
// Accepts a header / payload / parity byte stream, buffers every accepted
// beat in a small hold queue in front of the destination FIFO, keeps a
// running XOR parity, and checks the payload length against the header.
// Parity and length errors are reported with sticky flags and a
// saturating bad-packet counter.
//
// Ports:
//   clock        system clock, rising edge
//   resetn       synchronous active-low reset
//   pkt_valid    upstream beat valid (low while in PAYLOAD = parity byte)
//   data_in      upstream data
//   in_ready     beat accepted this cycle when high
//   fifo_full    destination FIFO full
//   dout         data to FIFO
//   dout_wr      FIFO write strobe, one per beat
//   dest_addr    destination address of the current packet
//   addr_valid   high from header accept until the check completes
//   clr_err      clears err / len_err / parity_done
//   parity_done  sticky, packet checked
//   err          sticky parity mismatch
//   len_err      sticky length mismatch
//   err_count    saturating count of bad packets
module router_reg_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 2,
  parameter int HOLD_DEPTH = 2,
  parameter int LEN_CHECK  = 1,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  in_ready,
  input  logic                  fifo_full,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_wr,
  output logic [ADDR_BITS-1:0]  dest_addr,
  output logic                  addr_valid,
  input  logic                  clr_err,
  output logic                  parity_done,
  output logic                  err,
  output logic                  len_err,
  output logic [ERR_CNT_W-1:0]  err_count
);

  localparam int LEN_W = DATA_WIDTH - ADDR_BITS;
  localparam int CNT_W = $clog2(HOLD_DEPTH + 1);
  localparam int PTR_W = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_CHECK
  } state_t;

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   hold_q [HOLD_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q;
  logic [PTR_W-1:0]        rd_ptr_q;
  logic [CNT_W-1:0]        count_q;
  logic [CNT_W-1:0]        count_d;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W:0]          beat_cnt_q;
  logic [DATA_WIDTH-1:0]   int_par_q;
  logic [DATA_WIDTH-1:0]   pkt_par_q;
  logic                    push;
  logic                    pop;
  logic                    par_mis;
  logic                    len_mis;

  // Queue pointers wrap explicitly so HOLD_DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(HOLD_DEPTH - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = p + PTR_W'(1);
    end
  endfunction

  // Readiness depends only on occupancy; a pop in the same cycle does not
  // free a slot early.
  assign in_ready = (count_q < CNT_W'(HOLD_DEPTH));

  // In PAYLOAD every accepted cycle carries a beat: pkt_valid low is the
  // parity byte, which is forwarded like any other beat. CHECK accepts none.
  assign push = in_ready &&
                (((state_q == S_IDLE) && pkt_valid) || (state_q == S_PAYLOAD));
  assign pop  = (count_q != '0) && !fifo_full;

  assign par_mis = (pkt_par_q != int_par_q);
  assign len_mis = (LEN_CHECK != 0) && (beat_cnt_q != {1'b0, len_q});

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Hold queue storage: contents are meaningless until pointed at, so no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      hold_q[wr_ptr_q] <= data_in;
    end
  end

  // Hold queue control and FIFO write port.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout     <= '0;
      dout_wr  <= 1'b0;
    end else begin
      count_q <= count_d;
      dout_wr <= pop;
      if (pop) begin
        dout     <= hold_q[rd_ptr_q];
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      if (push) begin
        wr_ptr_q <= next_ptr(wr_ptr_q);
      end
    end
  end

  // Packet FSM with registered status outputs.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      dest_addr   <= '0;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      int_par_q   <= '0;
      pkt_par_q   <= '0;
      addr_valid  <= 1'b0;
      parity_done <= 1'b0;
      err         <= 1'b0;
      len_err     <= 1'b0;
      err_count   <= '0;
    end else begin
      // Later assignments in the case below take precedence over this clear.
      if (clr_err) begin
        parity_done <= 1'b0;
        err         <= 1'b0;
        len_err     <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (pkt_valid && in_ready) begin
            dest_addr   <= data_in[ADDR_BITS-1:0];
            len_q       <= data_in[DATA_WIDTH-1:ADDR_BITS];
            int_par_q   <= data_in;
            beat_cnt_q  <= '0;
            addr_valid  <= 1'b1;
            parity_done <= 1'b0;
            err         <= 1'b0;
            len_err     <= 1'b0;
            state_q     <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (in_ready) begin
            if (pkt_valid) begin
              int_par_q <= int_par_q ^ data_in;
              if (beat_cnt_q != '1) begin
                beat_cnt_q <= beat_cnt_q + (LEN_W + 1)'(1);
              end
            end else begin
              pkt_par_q <= data_in;
              state_q   <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          parity_done <= 1'b1;
          err         <= par_mis;
          len_err     <= len_mis;
          if ((par_mis || len_mis) && (err_count != '1)) begin
            err_count <= err_count + ERR_CNT_W'(1);
          end
          addr_valid  <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_router_reg_gen.sv
// tb_router_reg_gen: self-checking bench for router_reg_gen.
// Fixed packet table, hand-written multi-cycle sequences (clear priority,
// backpressure, reset mid-packet) and randomized packets checked against a
// packet-level reference model (beat order queue, XOR reduction, length).
module tb_router_reg_gen;

  logic       clock;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       in_ready;
  logic       fifo_full;
  logic [7:0] dout;
  logic       dout_wr;
  logic [1:0] dest_addr;
  logic       addr_valid;
  logic       clr_err;
  logic       parity_done;
  logic       err;
  logic       len_err;
  logic [7:0] err_count;

  router_reg_gen #(
    .DATA_WIDTH(8), .ADDR_BITS(2), .HOLD_DEPTH(2), .LEN_CHECK(1), .ERR_CNT_W(8)
  ) dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .in_ready(in_ready), .fifo_full(fifo_full), .dout(dout), .dout_wr(dout_wr),
    .dest_addr(dest_addr), .addr_valid(addr_valid), .clr_err(clr_err),
    .parity_done(parity_done), .err(err), .len_err(len_err), .err_count(err_count)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int bp_mode = 0;        // 0: fifo never full, 1: random, 2: always full
  int exp_cnt = 0;        // model of err_count
  logic [7:0] exp_q[$];   // beats expected on the FIFO side, in order

  typedef struct {
    logic [7:0]      hdr;
    int              n;
    logic [7:0][7:0] pl;
    logic [7:0]      par;
    logic            e_err;
    logic            e_len;
  } vec_t;

  vec_t vecs[6];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO-full driver; updates at #2 so stimulus written at #1 takes effect.
  initial begin
    fifo_full = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      case (bp_mode)
        1:       fifo_full = ($urandom_range(0, 3) == 0);
        2:       fifo_full = 1'b1;
        default: fifo_full = 1'b0;
      endcase
    end
  end

  // FIFO-side scoreboard: every write strobe must carry the next expected beat.
  always @(negedge clock) begin
    if (dout_wr) begin
      if (exp_q.size() == 0) begin
        chk("spurious_dout_wr", 32'd1, 32'd0);
      end else begin
        chk("dout_order", {24'd0, dout}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input logic v, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    pkt_valid = v;
    data_in   = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clock);
      #1;
      exp_q.push_back(d);
    end
  endtask

  task automatic check_status(input string tag, input logic [1:0] addr,
                              input logic e_err, input logic e_len);
    chk({tag, "_parity_done"}, {31'd0, parity_done}, 32'd1);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, e_err});
    chk({tag, "_len_err"}, {31'd0, len_err}, {31'd0, e_len});
    chk({tag, "_err_count"}, {24'd0, err_count}, exp_cnt);
    chk({tag, "_addr_valid"}, {31'd0, addr_valid}, 32'd0);
    chk({tag, "_dest_addr"}, {30'd0, dest_addr}, {30'd0, addr});
  endtask

  task automatic bump_cnt(input logic e_err, input logic e_len);
    if ((e_err || e_len) && exp_cnt < 255) exp_cnt++;
  endtask

  task automatic run_pkt(input logic [7:0] hdr, input int n, input logic [7:0][7:0] pl,
                         input logic [7:0] par, input logic e_err, input logic e_len,
                         input string tag);
    send_beat(1'b1, hdr);
    chk({tag, "_addr_valid_hdr"}, {31'd0, addr_valid}, 32'd1);
    chk({tag, "_dest_addr_hdr"}, {30'd0, dest_addr}, {30'd0, hdr[1:0]});
    for (int i = 0; i < n; i++) send_beat(1'b1, pl[i]);
    send_beat(1'b0, par);
    @(posedge clock);
    #1;
    bump_cnt(e_err, e_len);
    check_status(tag, hdr[1:0], e_err, e_len);
  endtask

  initial begin
    logic [7:0][7:0] pl;
    logic [7:0] x, par, hdr;
    logic [5:0] len;
    int n;

    resetn = 1'b0; pkt_valid = 1'b0; data_in = 8'h00; clr_err = 1'b0;

    vecs[0] = '{hdr: 8'h0D, n: 3, pl: {40'd0, 8'h33, 8'h22, 8'h11}, par: 8'h0D, e_err: 1'b0, e_len: 1'b0};
    vecs[1] = '{hdr: 8'h0D, n: 3, pl: {40'd0, 8'h33, 8'h22, 8'h11}, par: 8'h0C, e_err: 1'b1, e_len: 1'b0};
    vecs[2] = '{hdr: 8'h0D, n: 2, pl: {48'd0, 8'h22, 8'h11},        par: 8'h3E, e_err: 1'b0, e_len: 1'b1};
    vecs[3] = '{hdr: 8'h02, n: 0, pl: 64'd0,                        par: 8'h02, e_err: 1'b0, e_len: 1'b0};
    vecs[4] = '{hdr: 8'h06, n: 1, pl: {56'd0, 8'hAA},               par: 8'hAC, e_err: 1'b0, e_len: 1'b0};
    vecs[5] = '{hdr: 8'h08, n: 1, pl: {56'd0, 8'h01},               par: 8'hFF, e_err: 1'b1, e_len: 1'b1};

    repeat (3) @(posedge clock);
    #1;
    chk("rst_dout", {24'd0, dout}, 32'd0);
    chk("rst_dout_wr", {31'd0, dout_wr}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_dest_addr", {30'd0, dest_addr}, 32'd0);
    chk("rst_addr_valid", {31'd0, addr_valid}, 32'd0);
    chk("rst_parity_done", {31'd0, parity_done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_len_err", {31'd0, len_err}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    resetn = 1'b1;
    @(posedge clock);
    #1;

    for (int k = 0; k < 6; k++) begin
      run_pkt(vecs[k].hdr, vecs[k].n, vecs[k].pl, vecs[k].par,
              vecs[k].e_err, vecs[k].e_len, $sformatf("vec%0d", k));
    end

    // clr_err clears flags but not the counter.
    clr_err = 1'b1;
    @(posedge clock);
    #1;
    clr_err = 1'b0;
    chk("clr_parity_done", {31'd0, parity_done}, 32'd0);
    chk("clr_err", {31'd0, err}, 32'd0);
    chk("clr_len_err", {31'd0, len_err}, 32'd0);
    chk("clr_err_count_kept", {24'd0, err_count}, exp_cnt);

    // clr_err held through the check cycle: the check result wins, then clears.
    send_beat(1'b1, 8'h0D);
    send_beat(1'b1, 8'h11);
    send_beat(1'b1, 8'h22);
    send_beat(1'b1, 8'h33);
    send_beat(1'b0, 8'h0C);
    pkt_valid = 1'b0;
    clr_err = 1'b1;
    @(posedge clock);
    #1;
    bump_cnt(1'b1, 1'b0);
    chk("prio_parity_done", {31'd0, parity_done}, 32'd1);
    chk("prio_err", {31'd0, err}, 32'd1);
    chk("prio_err_count", {24'd0, err_count}, exp_cnt);
    @(posedge clock);
    #1;
    clr_err = 1'b0;
    chk("prio_err_cleared", {31'd0, err}, 32'd0);

    // Backpressure: queue fills to two and nothing leaves while full.
    repeat (4) begin @(posedge clock); #1; end
    bp_mode = 2;
    send_beat(1'b1, 8'h0D);
    send_beat(1'b1, 8'h11);
    pkt_valid = 1'b1;
    data_in   = 8'h22;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      chk("bp_no_dout_wr", {31'd0, dout_wr}, 32'd0);
    end
    @(posedge clock);
    #1;
    bp_mode = 0;
    send_beat(1'b1, 8'h22);
    send_beat(1'b1, 8'h33);
    send_beat(1'b0, 8'h0D);
    pkt_valid = 1'b0;
    @(posedge clock);
    #1;
    check_status("bp", 2'd1, 1'b0, 1'b0);
    repeat (4) begin @(posedge clock); #1; end
    chk("bp_all_beats_out", exp_q.size(), 32'd0);

    // Reset after the second payload beat drops the packet.
    send_beat(1'b1, 8'h0D);
    send_beat(1'b1, 8'h11);
    send_beat(1'b1, 8'h22);
    resetn    = 1'b0;
    pkt_valid = 1'b0;
    @(posedge clock);
    #1;
    exp_q.delete();
    exp_cnt = 0;
    resetn  = 1'b1;
    @(negedge clock);
    chk("mid_rst_dout", {24'd0, dout}, 32'd0);
    chk("mid_rst_dout_wr", {31'd0, dout_wr}, 32'd0);
    chk("mid_rst_addr_valid", {31'd0, addr_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    #1;
    run_pkt(8'h02, 0, 64'd0, 8'h02, 1'b0, 1'b0, "zero_len");

    // Randomized packets against the packet-level model.
    bp_mode = 1;
    for (int p = 0; p < 40; p++) begin
      n   = $urandom_range(0, 7);
      len = ($urandom_range(0, 1) == 1) ? 6'(n) : 6'($urandom_range(0, 9));
      hdr = {len, 2'($urandom_range(0, 3))};
      x   = hdr;
      for (int i = 0; i < 8; i++) begin
        pl[i] = 8'($urandom_range(0, 255));
        if (i < n) x = x ^ pl[i];
      end
      par = ($urandom_range(0, 1) == 1) ? x : (x ^ 8'($urandom_range(1, 255)));
      run_pkt(hdr, n, pl, par, (par != x), (int'(len) != n), $sformatf("rnd%0d", p));
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    end
    bp_mode = 0;
    repeat (12) begin @(posedge clock); #1; end
    chk("final_drain", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
